// File: rtl/fd_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO carrying
// {instr, pc, pcplus4, arm}, with a NOP bubble on the outputs when empty.
module fd_queue #(
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 4,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [XLEN-1:0]              enq_instr,
  input  logic [XLEN-1:0]              enq_pc,
  input  logic [XLEN-1:0]              enq_pcplus4,
  input  logic                         enq_arm,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [XLEN-1:0]              deq_instr,
  output logic [XLEN-1:0]              deq_pc,
  output logic [XLEN-1:0]              deq_pcplus4,
  output logic                         deq_arm,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] instr_mem_r   [DEPTH];
  logic [XLEN-1:0] pc_mem_r      [DEPTH];
  logic [XLEN-1:0] pcplus4_mem_r [DEPTH];
  logic            arm_mem_r     [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          ovf_r;
  logic          full_s;
  logic          empty_s;
  logic          enq_fire_s;
  logic          deq_fire_s;

  assign full_s     = (count_r == CW'(DEPTH));
  assign empty_s    = (count_r == {CW{1'b0}});
  assign enq_fire_s = enq_valid & ~full_s & ~flush;
  assign deq_fire_s = ~empty_s & deq_ready & ~flush;

  assign enq_ready = ~full_s;
  assign deq_valid = ~empty_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign ovf       = ovf_r;

  // Occupancy next-state; a simultaneous enq and deq leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({enq_fire_s, deq_fire_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky overflow state; flush dominates any fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        count_r  <= {CW{1'b0}};
      end else begin
        if (enq_fire_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (deq_fire_s) rd_ptr_r <= rd_ptr_r + AW'(1);
        count_r <= count_nxt_s;
      end
      if (enq_valid && full_s && !flush) ovf_r <= 1'b1;
    end
  end

  // Entry storage is intentionally unreset; it is only visible when non-empty.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      instr_mem_r[wr_ptr_r]   <= enq_instr;
      pc_mem_r[wr_ptr_r]      <= enq_pc;
      pcplus4_mem_r[wr_ptr_r] <= enq_pcplus4;
      arm_mem_r[wr_ptr_r]     <= enq_arm;
    end
  end

  // Head presentation straight from storage, bubble values when empty.
  always_comb begin
    deq_instr   = NOP_INSTR;
    deq_pc      = {XLEN{1'b0}};
    deq_pcplus4 = {XLEN{1'b0}};
    deq_arm     = 1'b0;
    if (empty_s) begin
      deq_instr   = NOP_INSTR;
      deq_pc      = {XLEN{1'b0}};
      deq_pcplus4 = {XLEN{1'b0}};
      deq_arm     = 1'b0;
    end else begin
      deq_instr   = instr_mem_r[rd_ptr_r];
      deq_pc      = pc_mem_r[rd_ptr_r];
      deq_pcplus4 = pcplus4_mem_r[rd_ptr_r];
      deq_arm     = arm_mem_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_fd_queue.sv
// Self-checking bench for fd_queue: table-driven fill/drain vectors plus
// scoreboarded corner-case sequences (simultaneous enq/deq, flush, stall, reset).
module tb_fd_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        arm;
  } entry_t;

  typedef struct {
    logic        ev;
    logic        dr;
    logic        fl;
    logic [31:0] instr;
    int          exp_count;
    logic [31:0] exp_head;
    logic        exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_instr;
  logic [31:0] enq_pc;
  logic [31:0] enq_pcplus4;
  logic        enq_arm;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [31:0] deq_pcplus4;
  logic        deq_arm;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;

  int     checks   = 0;
  int     failures = 0;
  entry_t sbq[$];
  logic   m_ovf    = 1'b0;
  vec_t   tbl[9];

  fd_queue #(.XLEN(32), .DEPTH(4), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_instr(enq_instr), .enq_pc(enq_pc), .enq_pcplus4(enq_pcplus4), .enq_arm(enq_arm),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_pcplus4(deq_pcplus4), .deq_arm(deq_arm),
    .count(count), .full(full), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] instr);
    entry_t e;
    e.instr = instr;
    e.pc    = instr ^ 32'h0000_1000;
    e.pcp4  = (instr ^ 32'h0000_1000) + 32'd4;
    e.arm   = instr[0];
    return e;
  endfunction

  // One clock of stimulus: scoreboard push on enq fire, pop+compare on deq fire.
  task automatic cycle(input logic ev, input entry_t e, input logic dr, input logic fl);
    entry_t h;
    bit     m_full;
    bit     do_enq;
    bit     do_deq;
    enq_valid   = ev;
    enq_instr   = e.instr;
    enq_pc      = e.pc;
    enq_pcplus4 = e.pcp4;
    enq_arm     = e.arm;
    deq_ready   = dr;
    flush       = fl;
    #1;
    m_full = (sbq.size() == 4);
    do_enq = ev && !m_full && !fl;
    do_deq = (sbq.size() > 0) && dr && !fl;
    chk("enq_ready", {31'd0, enq_ready}, {31'd0, !m_full});
    if (do_deq) begin
      h = sbq.pop_front();
      chk("pop_instr", deq_instr, h.instr);
      chk("pop_pc", deq_pc, h.pc);
      chk("pop_pcplus4", deq_pcplus4, h.pcp4);
      chk("pop_arm", {31'd0, deq_arm}, {31'd0, h.arm});
    end
    if (fl) sbq.delete();
    else if (do_enq) sbq.push_back(e);
    if (ev && m_full && !fl) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    chk("count", {29'd0, count}, sbq.size());
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    chk("deq_valid", {31'd0, deq_valid}, {31'd0, sbq.size() > 0});
    chk("empty", {31'd0, empty}, {31'd0, sbq.size() == 0});
    chk("full", {31'd0, full}, {31'd0, sbq.size() == 4});
    if (sbq.size() > 0) chk("head_instr", deq_instr, sbq[0].instr);
    else                chk("bubble_instr", deq_instr, NOP);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hA000_0000, 1, 32'hA000_0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'hB000_0001, 2, 32'hA000_0000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'hC000_0000, 3, 32'hA000_0000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hD000_0001, 4, 32'hA000_0000, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'hE000_0000, 4, 32'hA000_0000, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 3, 32'hB000_0001, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2, 32'hC000_0000, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1, 32'hD000_0001, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 0, NOP,          1'b1};

    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_instr = 32'd0; enq_pc = 32'd0; enq_pcplus4 = 32'd0; enq_arm = 1'b0;
    #3;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_deq_instr", deq_instr, NOP);
    chk("rst_deq_pc", deq_pc, 32'd0);
    chk("rst_deq_pcplus4", deq_pcplus4, 32'd0);
    #9;
    rst = 1'b1;

    // Fill to full, overflow, then drain (table-driven).
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].ev, mk(tbl[i].instr), tbl[i].dr, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), {29'd0, count}, tbl[i].exp_count);
      chk($sformatf("tbl%0d_head", i), deq_instr, tbl[i].exp_head);
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].exp_ovf});
    end

    // count==1 with simultaneous enq and deq, across pointer wrap.
    cycle(1'b1, mk(32'h5800_0000), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, mk(32'h5900_0000 + i), 1'b1, 1'b0);
      chk("swap_count", {29'd0, count}, 32'd1);
      chk("swap_head", deq_instr, 32'h5900_0000 + i);
    end
    cycle(1'b0, mk(32'd0), 1'b1, 1'b0);

    // Flush with three entries while offering a fourth.
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'h6000_0000 + i), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h6F00_0000), 1'b1, 1'b1);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("flush_ovf_kept", {31'd0, ovf}, 32'd1);
    cycle(1'b0, mk(32'd0), 1'b0, 1'b0);
    chk("flush_not_stored", {31'd0, deq_valid}, 32'd0);

    // Head held stable under a 5-cycle stall.
    begin
      entry_t p;
      p.instr = 32'h7000_0000; p.pc = 32'h100; p.pcp4 = 32'h104; p.arm = 1'b1;
      cycle(1'b1, p, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(i < 2, mk(32'h7100_0000 + i), 1'b0, 1'b0);
      chk("stall_pc", deq_pc, 32'h100);
      chk("stall_pcplus4", deq_pcplus4, 32'h104);
      chk("stall_arm", {31'd0, deq_arm}, 32'd1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, mk(32'd0), 1'b1, 1'b0);

    // Asynchronous reset mid-operation with two entries queued.
    cycle(1'b1, mk(32'h8000_0000), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h8100_0001), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    sbq.delete();
    m_ovf = 1'b0;
    #1;
    chk("mrst_count", {29'd0, count}, 32'd0);
    chk("mrst_ovf", {31'd0, ovf}, 32'd0);
    chk("mrst_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("mrst_deq_instr", deq_instr, NOP);
    enq_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mrst_held_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, mk(32'h9A00_0000), 1'b0, 1'b0);
    chk("post_rst_head", deq_instr, 32'h9A00_0000);
    chk("post_rst_count", {29'd0, count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
